// File: rtl/mha_mul_pkg.sv
// Shared types and constants for the MHA iterative fixed-point multipliers.
// Holds the control-state enum, the step-count function and the signed range limits.
package mha_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    // Number of CALC cycles needed to consume the WIDTH-1 magnitude bits of the multiplier.
    function automatic int mul_steps(input int width, input int digit);
        return (width - 1 + digit - 1) / digit;
    endfunction

    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/mul_shift_digit.sv
// Combinational partial product: 2*WIDTH-bit multiplicand times one unsigned DIGIT-bit digit.
module mul_shift_digit #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 5
) (
    input  logic [2*WIDTH-1:0] mcand_i,
    input  logic [DIGIT-1:0]   digit_i,
    output logic [2*WIDTH-1:0] prod_o
);

    localparam int PW = 2 * WIDTH;

    assign prod_o = mcand_i * PW'(digit_i);

endmodule

// File: rtl/mul_fx_iter.sv
// Iterative signed fixed-point multiplier, DIGIT multiplier bits per cycle, with rounding,
// saturation and an overflow flag. Valid/ready handshake on both the operand and result sides.
module mul_fx_iter
    import mha_mul_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 13,
    parameter int DIGIT = 5,
    parameter int ROUND = 1,
    parameter int SAT   = 1
) (
    input  logic             I_CLK,
    input  logic             I_RST,
    input  logic             I_VLD,
    output logic             O_RDY,
    input  logic [WIDTH-1:0] I_M1,
    input  logic [WIDTH-1:0] I_M2,
    output logic             O_VLD,
    input  logic             I_RDY,
    output logic [WIDTH-1:0] O_PRODUCT,
    output logic             O_OVF,
    output logic [1:0]       O_STATE
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid, once raised, is held with its data until that edge.

    localparam int PW      = 2 * WIDTH;
    localparam int N       = mul_steps(WIDTH, DIGIT);
    localparam int CW      = $clog2(N + 1);
    // The shifted multiplicand in the last step is M1 << (N-1)*DIGIT; the sign-bit
    // correction M1 << (WIDTH-1) is recovered from it with this extra shift.
    localparam int SIGN_SH = WIDTH - 1 - (N - 1) * DIGIT;
    localparam int RND_SH  = (FRAC > 0) ? (FRAC - 1) : 0;

    localparam logic [PW-1:0]        RND_ADD = (ROUND != 0 && FRAC > 0) ? (PW'(1) << RND_SH) : '0;
    localparam logic signed [PW-1:0] R_MAX   = PW'(sat_max(WIDTH));
    localparam logic signed [PW-1:0] R_MIN   = PW'(sat_min(WIDTH));
    localparam logic [CW-1:0]        LAST    = CW'(N - 1);

    mul_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     m1_q, m1_d;
    logic [WIDTH-2:0]  m2_q, m2_d;
    logic              sign_q, sign_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]  prod_q, prod_d;
    logic              ovf_q, ovf_d;

    logic [PW-1:0]        partial;
    logic [PW-1:0]        acc_sum;
    logic [PW-1:0]        full_p;
    logic [PW-1:0]        rounded;
    logic signed [PW-1:0] r_val;
    logic                 over_hi;
    logic                 over_lo;

    mul_shift_digit #(
        .WIDTH(WIDTH),
        .DIGIT(DIGIT)
    ) u_digit (
        .mcand_i(m1_q),
        .digit_i(m2_q[DIGIT-1:0]),
        .prod_o (partial)
    );

    assign acc_sum = acc_q + partial;
    assign full_p  = acc_sum - (sign_q ? (m1_q << SIGN_SH) : '0);
    assign rounded = full_p + RND_ADD;
    assign r_val   = $signed(rounded) >>> FRAC;
    assign over_hi = (r_val > R_MAX);
    assign over_lo = (r_val < R_MIN);

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            m1_q    <= '0;
            m2_q    <= '0;
            sign_q  <= 1'b0;
            acc_q   <= '0;
            prod_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m1_q    <= m1_d;
            m2_q    <= m2_d;
            sign_q  <= sign_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m1_d    = m1_q;
        m2_d    = m2_q;
        sign_d  = sign_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (I_VLD) begin
                    state_d = ST_CALC;
                    cnt_d   = '0;
                    m1_d    = {{WIDTH{I_M1[WIDTH-1]}}, I_M1};
                    m2_d    = I_M2[WIDTH-2:0];
                    sign_d  = I_M2[WIDTH-1];
                    acc_d   = '0;
                end
            end
            ST_CALC: begin
                acc_d = acc_sum;
                m1_d  = m1_q << DIGIT;
                m2_d  = m2_q >> DIGIT;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                    ovf_d   = over_hi | over_lo;
                    if (SAT != 0 && over_hi) begin
                        prod_d = R_MAX[WIDTH-1:0];
                    end else if (SAT != 0 && over_lo) begin
                        prod_d = R_MIN[WIDTH-1:0];
                    end else begin
                        prod_d = r_val[WIDTH-1:0];
                    end
                end
            end
            ST_DONE: begin
                if (I_RDY) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign O_RDY     = (state_q == ST_IDLE);
    assign O_VLD     = (state_q == ST_DONE);
    assign O_PRODUCT = prod_q;
    assign O_OVF     = ovf_q;
    assign O_STATE   = state_q;

endmodule

// File: tb/tb_mul_fx_iter.sv
// Bench for mul_fx_iter: five instances (defaults, ROUND=0, SAT=0, 8-bit, 24-bit) share one
// handshake; every result is compared against a plain-arithmetic fixed-point model.
module tb_mul_fx_iter;
  import mha_mul_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic        rdy = 1'b0;
  logic [23:0] m1_bus = '0;
  logic [23:0] m2_bus = '0;

  logic [4:0]  o_rdy;
  logic [4:0]  o_vld;
  logic [4:0]  o_ovf;
  logic [1:0]  st [5];
  logic [15:0] p0, p1, p2;
  logic [7:0]  p3;
  logic [23:0] p4;
  logic [24:0] act [5];

  int n_tests = 0;
  int n_fail  = 0;
  logic [24:0] exp_q[$];

  int w_t   [5] = '{16, 16, 16, 8, 24};
  int frac_t[5] = '{13, 13, 13, 4, 16};
  int rnd_t [5] = '{1, 0, 1, 1, 1};
  int sat_t [5] = '{1, 1, 0, 1, 1};

  assign act[0] = {o_ovf[0], 8'h00, p0};
  assign act[1] = {o_ovf[1], 8'h00, p1};
  assign act[2] = {o_ovf[2], 8'h00, p2};
  assign act[3] = {o_ovf[3], 16'h0000, p3};
  assign act[4] = {o_ovf[4], p4};

  mul_fx_iter #(.WIDTH(16), .FRAC(13), .DIGIT(5), .ROUND(1), .SAT(1)) dut0 (
    .I_CLK(clk), .I_RST(rst), .I_VLD(vld), .O_RDY(o_rdy[0]), .I_M1(m1_bus[15:0]), .I_M2(m2_bus[15:0]),
    .O_VLD(o_vld[0]), .I_RDY(rdy), .O_PRODUCT(p0), .O_OVF(o_ovf[0]), .O_STATE(st[0]));
  mul_fx_iter #(.WIDTH(16), .FRAC(13), .DIGIT(5), .ROUND(0), .SAT(1)) dut1 (
    .I_CLK(clk), .I_RST(rst), .I_VLD(vld), .O_RDY(o_rdy[1]), .I_M1(m1_bus[15:0]), .I_M2(m2_bus[15:0]),
    .O_VLD(o_vld[1]), .I_RDY(rdy), .O_PRODUCT(p1), .O_OVF(o_ovf[1]), .O_STATE(st[1]));
  mul_fx_iter #(.WIDTH(16), .FRAC(13), .DIGIT(5), .ROUND(1), .SAT(0)) dut2 (
    .I_CLK(clk), .I_RST(rst), .I_VLD(vld), .O_RDY(o_rdy[2]), .I_M1(m1_bus[15:0]), .I_M2(m2_bus[15:0]),
    .O_VLD(o_vld[2]), .I_RDY(rdy), .O_PRODUCT(p2), .O_OVF(o_ovf[2]), .O_STATE(st[2]));
  mul_fx_iter #(.WIDTH(8), .FRAC(4), .DIGIT(3), .ROUND(1), .SAT(1)) dut3 (
    .I_CLK(clk), .I_RST(rst), .I_VLD(vld), .O_RDY(o_rdy[3]), .I_M1(m1_bus[7:0]), .I_M2(m2_bus[7:0]),
    .O_VLD(o_vld[3]), .I_RDY(rdy), .O_PRODUCT(p3), .O_OVF(o_ovf[3]), .O_STATE(st[3]));
  mul_fx_iter #(.WIDTH(24), .FRAC(16), .DIGIT(8), .ROUND(1), .SAT(1)) dut4 (
    .I_CLK(clk), .I_RST(rst), .I_VLD(vld), .O_RDY(o_rdy[4]), .I_M1(m1_bus), .I_M2(m2_bus),
    .O_VLD(o_vld[4]), .I_RDY(rdy), .O_PRODUCT(p4), .O_OVF(o_ovf[4]), .O_STATE(st[4]));

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic longint sext(input logic [23:0] x, input int w);
    longint v;
    v = longint'(x) & ((longint'(1) <<< w) - 1);
    if (v >= (longint'(1) <<< (w - 1))) v = v - (longint'(1) <<< w);
    return v;
  endfunction

  function automatic logic [24:0] model(input logic [23:0] a, input logic [23:0] b, input int i);
    longint p, r, mx, mn;
    logic ovf;
    p = sext(a, w_t[i]) * sext(b, w_t[i]);
    if (rnd_t[i] != 0 && frac_t[i] > 0) p = p + (longint'(1) <<< (frac_t[i] - 1));
    r  = p >>> frac_t[i];
    mx = (longint'(1) <<< (w_t[i] - 1)) - 1;
    mn = -(mx + 1);
    ovf = (r > mx) || (r < mn);
    if (sat_t[i] != 0 && r > mx) r = mx;
    if (sat_t[i] != 0 && r < mn) r = mn;
    r = r & ((longint'(1) <<< w_t[i]) - 1);
    return {ovf, 24'(r)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_accept(input logic [23:0] a, input logic [23:0] b, input bit push);
    int guard = 0;
    while (o_rdy[0] !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    n_tests++;
    if (o_rdy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_wait: O_RDY=%b required 1", o_rdy[0]);
    end
    m1_bus = a;
    m2_bus = b;
    vld    = 1'b1;
    if (push) for (int i = 0; i < 5; i++) exp_q.push_back(model(a, b, i));
    tick();
    vld = 1'b0;
  endtask

  // Called one cycle after the accept edge; checks latency, results, stall stability, release.
  task automatic collect(input int stall, output logic [24:0] got0, output logic [24:0] got1,
                         output logic [24:0] got2);
    int lat = 0;
    logic [24:0] e [5];
    while (o_vld[0] !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    n_tests++;
    if (lat != 3) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles required 3", lat);
    end
    for (int i = 0; i < 5; i++) begin
      e[i] = (exp_q.size() > 0) ? exp_q.pop_front() : 25'h1ffffff;
      n_tests++;
      if (o_vld[i] !== 1'b1 || act[i] !== e[i]) begin
        n_fail++;
        $display("FAIL result dut%0d: vld=%b got %h required %h", i, o_vld[i], act[i], e[i]);
      end
    end
    got0 = act[0];
    got1 = act[1];
    got2 = act[2];
    for (int k = 0; k < stall; k++) begin
      tick();
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (o_vld[i] !== 1'b1 || o_rdy[i] !== 1'b0 || act[i] !== e[i]) begin
          n_fail++;
          $display("FAIL hold dut%0d: vld=%b rdy=%b got %h required vld=1 rdy=0 %h",
                   i, o_vld[i], o_rdy[i], act[i], e[i]);
        end
      end
    end
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    n_tests++;
    if (o_vld !== 5'b00000 || o_rdy !== 5'b11111) begin
      n_fail++;
      $display("FAIL release: vld=%b rdy=%b required 00000 11111", o_vld, o_rdy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    vld = 1'b1;
    m1_bus = 24'h002000;
    m2_bus = 24'h002000;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (o_rdy[i] !== 1'b1 || o_vld[i] !== 1'b0 || act[i] !== 25'h0 || st[i] !== ST_IDLE) begin
        n_fail++;
        $display("FAIL reset dut%0d: rdy=%b vld=%b out=%h required rdy=1 vld=0 out=0", i, o_rdy[i],
                 o_vld[i], act[i]);
      end
    end
    vld = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unity();
    logic [24:0] g0, g1, g2;
    drive_accept(24'h002000, 24'h002000, 1'b1);
    collect(0, g0, g1, g2);
    n_tests++;
    if (g0 !== {1'b0, 24'h002000}) begin
      n_fail++;
      $display("FAIL unity: got %h required %h", g0, {1'b0, 24'h002000});
    end
  endtask

  task automatic test_sign();
    logic [23:0] ta [3] = '{24'h00e000, 24'h00e000, 24'h001000};
    logic [23:0] tb [3] = '{24'h002000, 24'h00e000, 24'h00f000};
    logic [15:0] tr [3] = '{16'he000, 16'h2000, 16'hf800};
    logic [24:0] g0, g1, g2;
    for (int t = 0; t < 3; t++) begin
      drive_accept(ta[t], tb[t], 1'b1);
      collect(0, g0, g1, g2);
      n_tests++;
      if (g0 !== {9'h000, tr[t]}) begin
        n_fail++;
        $display("FAIL sign%0d: got %h required %h", t, g0, {9'h000, tr[t]});
      end
    end
  endtask

  task automatic test_overflow();
    logic [23:0] ta [2] = '{24'h007fff, 24'h008000};
    logic [15:0] wr [2] = '{16'hfff8, 16'h0000};
    logic [24:0] g0, g1, g2;
    for (int t = 0; t < 2; t++) begin
      drive_accept(ta[t], ta[t], 1'b1);
      collect(1, g0, g1, g2);
      n_tests++;
      if (g0 !== {9'h100, 16'h7fff}) begin
        n_fail++;
        $display("FAIL ovf_sat%0d: got %h required %h", t, g0, {9'h100, 16'h7fff});
      end
      n_tests++;
      if (g2 !== {9'h100, wr[t]}) begin
        n_fail++;
        $display("FAIL ovf_wrap%0d: got %h required %h", t, g2, {9'h100, wr[t]});
      end
    end
  endtask

  task automatic test_rounding();
    logic [24:0] g0, g1, g2;
    drive_accept(24'h000001, 24'h001000, 1'b1);
    collect(0, g0, g1, g2);
    n_tests++;
    if (g0 !== 25'h0000001 || g1 !== 25'h0000000) begin
      n_fail++;
      $display("FAIL rounding: got %h/%h required 0000001/0000000", g0, g1);
    end
  endtask

  task automatic test_backpressure();
    logic [24:0] e [5];
    logic [24:0] g0, g1, g2;
    int lat = 0;
    drive_accept(24'h003000, 24'h002800, 1'b1);
    while (o_vld[0] !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    for (int i = 0; i < 5; i++) e[i] = (exp_q.size() > 0) ? exp_q.pop_front() : 25'h1ffffff;
    n_tests++;
    if (lat != 3 || act[0] !== {9'h000, 16'h3c00}) begin
      n_fail++;
      $display("FAIL bp_first: lat=%0d got %h required lat=3 %h", lat, act[0], {9'h000, 16'h3c00});
    end
    m1_bus = 24'h001800;
    m2_bus = 24'h00e800;
    vld    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (o_vld[i] !== 1'b1 || o_rdy[i] !== 1'b0 || act[i] !== e[i]) begin
          n_fail++;
          $display("FAIL bp_hold dut%0d: vld=%b rdy=%b got %h required vld=1 rdy=0 %h",
                   i, o_vld[i], o_rdy[i], act[i], e[i]);
        end
      end
    end
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    n_tests++;
    if (o_rdy[0] !== 1'b1 || o_vld[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_idle: rdy=%b vld=%b required 1 0", o_rdy[0], o_vld[0]);
    end
    for (int i = 0; i < 5; i++) exp_q.push_back(model(m1_bus, m2_bus, i));
    tick();
    vld = 1'b0;
    n_tests++;
    if (o_rdy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept: rdy=%b required 0", o_rdy[0]);
    end
    collect(0, g0, g1, g2);
    n_tests++;
    if (g0 !== {9'h000, 16'hee00}) begin
      n_fail++;
      $display("FAIL bp_second: got %h required %h", g0, {9'h000, 16'hee00});
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [24:0] g0, g1, g2;
    drive_accept(24'h007fff, 24'h007fff, 1'b1);
    collect(0, g0, g1, g2);
    drive_accept(24'h002000, 24'h002000, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (o_vld[i] !== 1'b0 || act[i] !== 25'h0 || o_rdy[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_async dut%0d: vld=%b rdy=%b out=%h required 0 1 0", i, o_vld[i], o_rdy[i],
                 act[i]);
      end
    end
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_tests++;
      if (o_vld !== 5'b00000) begin
        n_fail++;
        $display("FAIL rst_no_result: vld=%b required 00000", o_vld);
      end
    end
    drive_accept(24'h004000, 24'h002000, 1'b1);
    collect(0, g0, g1, g2);
    n_tests++;
    if (g0 !== {9'h000, 16'h4000}) begin
      n_fail++;
      $display("FAIL rst_recover: got %h required %h", g0, {9'h000, 16'h4000});
    end
  endtask

  task automatic test_random();
    logic [24:0] g0, g1, g2;
    logic [23:0] a, b;
    for (int t = 0; t < 5000; t++) begin
      a = 24'($urandom);
      b = 24'($urandom);
      if ($urandom_range(0, 7) == 0) a = (a[0]) ? 24'h808080 : 24'h7f7fff;
      if ($urandom_range(0, 7) == 0) b = (b[0]) ? 24'h808080 : 24'h7f7fff;
      drive_accept(a, b, 1'b1);
      collect($urandom_range(0, 2), g0, g1, g2);
    end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_sign();
    test_overflow();
    test_rounding();
    test_backpressure();
    test_reset_mid_calc();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
